// File: rtl/bram_fifo_pkg.sv
// Shared constants, types and helpers for the block-RAM backed byte FIFO.
package bram_fifo_pkg;

    // Default geometry: 2048 x 8 fits exactly in one RAMB16
    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_ADDR_WIDTH    = 11;
    localparam int DEF_AFULL_THRESH  = 2040;
    localparam int DEF_AEMPTY_THRESH = 8;

    // RAMB16 geometry: 16 Kbit data array, 14 meaningful bit-granular address bits
    localparam int RAMB16_DATA_BITS = 16384;
    localparam int RAMB16_ADDR_BITS = 14;

    // Read pipeline: idle, or waiting for RAM port B data to appear on DOB
    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_WAIT = 1'b1
    } rd_state_e;

    // Ceiling log2, used to size the FIFO pointers from the depth
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Offset of the word address inside ADDRA[14:0] for a given data width
    function automatic int ramb16_addr_shift(input int data_width);
        if (data_width <= 1)       return 0;
        else if (data_width <= 2)  return 1;
        else if (data_width <= 4)  return 2;
        else if (data_width <= 9)  return 3;
        else if (data_width <= 18) return 4;
        else                       return 5;
    endfunction

    // Number of words a single RAMB16 holds at a given data width
    function automatic int ramb16_max_words(input int data_width);
        return RAMB16_DATA_BITS >> ramb16_addr_shift(data_width);
    endfunction

    // True when the word address plus its bit offset fits the RAMB16 address bus
    function automatic bit ramb16_addr_fits(input int addr_width, input int data_width);
        return (addr_width + ramb16_addr_shift(data_width)) <= RAMB16_ADDR_BITS;
    endfunction

endpackage

// File: rtl/bram_fifo_ctrl_if.sv
// User-side handshake of the BRAM FIFO: write/read requests, read data and status.
interface bram_fifo_ctrl_if
    import bram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    // The producer/consumer side drives requests and observes status
    modport master (
        output wr_en, din, rd_en,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    // The FIFO controller side
    modport slave (
        input  wr_en, din, rd_en,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/bram_fifo_ptr.sv
// Write/read pointers, occupancy and registered flags for the BRAM FIFO.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module bram_fifo_ptr
    import bram_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int AFULL_THRESH  = DEF_AFULL_THRESH,
    parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH,
    localparam int PTR_W        = clog2(2**ADDR_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic                  wr_ok,
    output logic                  rd_ok,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [PTR_W-1:0]      count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam logic [PTR_W-1:0] AFULL_LVL  = PTR_W'(AFULL_THRESH);
    localparam logic [PTR_W-1:0] AEMPTY_LVL = PTR_W'(AEMPTY_THRESH);

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr_next;
    logic [PTR_W-1:0] rptr_next;
    logic [PTR_W-1:0] count_next;
    logic             full_next;
    logic             empty_next;
    logic             afull_next;
    logic             aempty_next;

    // A write is refused when full, a read when empty; this also resolves
    // simultaneous requests without any fall-through path
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;
    assign waddr = wptr[PTR_W-2:0];
    assign raddr = rptr[PTR_W-2:0];

    // Next pointers and the flags they imply, so flags line up with the new count
    always_comb begin
        wptr_next   = wptr + {{(PTR_W-1){1'b0}}, wr_ok};
        rptr_next   = rptr + {{(PTR_W-1){1'b0}}, rd_ok};
        count_next  = wptr_next - rptr_next;
        empty_next  = (wptr_next == rptr_next);
        full_next   = (wptr_next[PTR_W-2:0] == rptr_next[PTR_W-2:0]) &&
                      (wptr_next[PTR_W-1] != rptr_next[PTR_W-1]);
        afull_next  = (count_next >= AFULL_LVL);
        aempty_next = (count_next <= AEMPTY_LVL);
    end

    // Pointer, count and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wptr         <= wptr_next;
            rptr         <= rptr_next;
            count        <= count_next;
            full         <= full_next;
            empty        <= empty_next;
            almost_full  <= afull_next;
            almost_empty <= aempty_next;
        end
    end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller driving one dual-port RAMB16: port A writes, port B reads.
// Read data leaves the RAM one cycle after the accept and is registered into
// dout on the following edge, giving a two-edge read latency.
module bram_fifo_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int AFULL_THRESH  = DEF_AFULL_THRESH,
    parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
    input  logic                  clk,
    input  logic                  rst,
    bram_fifo_ctrl_if.slave       fifo,
    output logic                  ram_ena,
    output logic [3:0]            ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dia,
    output logic                  ram_enb,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_dob
);

    logic                  wr_ok;
    logic                  rd_ok;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;

    rd_state_e             rd_state;
    rd_state_e             rd_state_next;
    logic                  capture;

    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dout_valid_q;
    logic                  overflow_q;
    logic                  underflow_q;

    bram_fifo_ptr #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .AFULL_THRESH  (AFULL_THRESH),
        .AEMPTY_THRESH (AEMPTY_THRESH)
    ) u_ptr (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (fifo.wr_en),
        .rd_en        (fifo.rd_en),
        .wr_ok        (wr_ok),
        .rd_ok        (rd_ok),
        .waddr        (waddr),
        .raddr        (raddr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    // RAM ports follow the current pointers combinationally; reads only ever
    // reach entries already written, so ports A and B never collide
    assign ram_ena   = wr_ok;
    assign ram_wea   = {4{wr_ok}};
    assign ram_addra = waddr;
    assign ram_dia   = fifo.din;
    assign ram_enb   = rd_ok;
    assign ram_addrb = raddr;

    assign fifo.dout         = dout_q;
    assign fifo.dout_valid   = dout_valid_q;
    assign fifo.full         = full;
    assign fifo.empty        = empty;
    assign fifo.almost_full  = almost_full;
    assign fifo.almost_empty = almost_empty;
    assign fifo.count        = count;
    assign fifo.overflow     = overflow_q;
    assign fifo.underflow    = underflow_q;

    // Read pipeline state register; reset drops any read still in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= RD_IDLE;
        end else begin
            rd_state <= rd_state_next;
        end
    end

    // Each accepted read waits one cycle for DOB, then is captured
    always_comb begin
        rd_state_next = RD_IDLE;
        capture       = 1'b0;
        case (rd_state)
            RD_IDLE: capture = 1'b0;
            RD_WAIT: capture = 1'b1;
            default: capture = 1'b0;
        endcase
        if (rd_ok) begin
            rd_state_next = RD_WAIT;
        end
    end

    // Output data register and one-cycle valid strobe; dout holds between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= capture;
            if (capture) begin
                dout_q <= ram_dob;
            end
        end
    end

    // Sticky error flags for refused requests, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (fifo.wr_en && full) begin
                overflow_q <= 1'b1;
            end
            if (fifo.rd_en && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

endmodule
